// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the divider.
//
// Handshake: the requester raises start_i with the operands and holds it
// until it observes ready_o=1. ready_o is a one-cycle pulse, and result_o
// carries {remainder, quotient} only in that cycle (zero otherwise).
// annul_i withdraws an accepted request or blocks a new one.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  // Requester side (EX stage or testbench driver)
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Iterative 32-bit restoring divider (signed DIV / unsigned DIVU).
// One quotient bit per cycle on a 65-bit partial remainder/quotient register.
// Results are {remainder, quotient} = {HI, LO}; divide by zero returns 0.
module div (
  input  logic       clk,
  input  logic       rst_n,
  div_if.slave       bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_e;

  state_e      state_q,   state_d;
  logic [5:0]  cnt_q,     cnt_d;
  logic [64:0] rem_q,     rem_d;      // {partial remainder, dividend/quotient}
  logic [31:0] divisor_q, divisor_d;  // |divisor|
  logic        neg_quo_q, neg_quo_d;  // quotient needs negating at the end
  logic        neg_rem_q, neg_rem_d;  // remainder needs negating at the end
  logic [63:0] final_q,   final_d;    // corrected result held for END
  logic        ready_q,   ready_d;
  logic [63:0] result_q,  result_d;

  // Datapath helpers for one shift-subtract step
  logic [64:0] shifted;
  logic [32:0] upper;
  logic [32:0] diff;
  logic        ge;
  logic [64:0] stepped;
  logic [31:0] step_quo;
  logic [31:0] step_rem;
  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;

  // Absolute values of the incoming operands (only negative signed ones flip)
  always_comb begin
    abs_dividend = bus.opdata1_i;
    abs_divisor  = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[31]) abs_dividend = ~bus.opdata1_i + 32'd1;
    if (bus.signed_div_i && bus.opdata2_i[31]) abs_divisor  = ~bus.opdata2_i + 32'd1;
  end

  // One restoring step: shift left, subtract the divisor if it fits
  always_comb begin
    shifted  = {rem_q[63:0], 1'b0};
    upper    = shifted[64:32];
    diff     = upper - {1'b0, divisor_q};
    ge       = (upper >= {1'b0, divisor_q});
    stepped  = ge ? {diff, shifted[31:1], 1'b1} : shifted;
    step_quo = stepped[31:0];
    step_rem = stepped[63:32];
  end

  // Next-state and next-output logic for the whole divider
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    final_d   = final_q;
    ready_d   = 1'b0;
    result_d  = 64'h0;

    case (state_q)
      S_IDLE: begin
        // ready_q is high only in the cycle right after END, so this keeps a
        // still-held start_i from re-launching the division just completed.
        if (bus.start_i && !bus.annul_i && !ready_q) begin
          if (bus.opdata2_i == 32'h0) begin
            state_d = S_DIVZERO;
          end else begin
            state_d   = S_ON;
            cnt_d     = 6'd0;
            rem_d     = {33'h0, abs_dividend};
            divisor_d = abs_divisor;
            neg_quo_d = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem_d = bus.signed_div_i & bus.opdata1_i[31];
          end
        end
      end

      S_DIVZERO: begin
        state_d = S_END;
        final_d = 64'h0;
      end

      S_ON: begin
        rem_d = stepped;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          // Last step: apply sign correction on the way into END
          state_d = S_END;
          final_d = {(neg_rem_q ? (~step_rem + 32'd1) : step_rem),
                     (neg_quo_q ? (~step_quo + 32'd1) : step_quo)};
        end
      end

      S_END: begin
        ready_d  = 1'b1;
        result_d = final_q;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A flush cancels anything in flight and suppresses the pending pulse
    if (bus.annul_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      ready_d  = 1'b0;
      result_d = 64'h0;
    end
  end

  // State and output registers; async active-low reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      rem_q     <= 65'h0;
      divisor_q <= 32'h0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      final_q   <= 64'h0;
      ready_q   <= 1'b0;
      result_q  <= 64'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      final_q   <= final_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_div.sv
// Bench for the iterative divider: directed corner cases plus random
// operands, scored against a plain-arithmetic reference model.
module tb_div;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  div_if bus ();

  div dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_cnt = 0;

  logic [63:0] exp_q[$];
  int          exp_edge_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ready_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready_o=1 expected none (edge %0d)", edge_cnt);
        end else begin
          check("result", bus.result_o, exp_q.pop_front());
          check("latency_edge", 64'(edge_cnt), 64'(exp_edge_q.pop_front()));
        end
      end else if (bus.result_o !== 64'h0) begin
        check("result_zero_when_idle", bus.result_o, 64'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int acc;
    int n;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    acc = edge_cnt + 1;
    exp_q.push_back(model(sgn, a, b));
    exp_edge_q.push_back(acc + ((b == 32'h0) ? 2 : 33));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (edge_cnt >= acc) begin
        // Operands already loaded: garbage here must not affect the result
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = 1'($urandom_range(0, 1));
      end
    end while (!bus.ready_o && n < 60);
    if (!bus.ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: got no ready_o expected one within 60 cycles");
      void'(exp_q.pop_back());
      void'(exp_edge_q.pop_back());
    end
    bus.start_i = 1'b0;
  endtask

  // Start a division and annul it so the flush is sampled k edges after load
  task automatic do_annul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int k);
    int acc;
    int seen;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    acc = edge_cnt + 1;
    while (edge_cnt < acc + k - 1) @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_to_idle", 64'(dbg_state), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_o) seen++;
      @(negedge clk);
    end
    check("annul_no_ready", 64'(seen), 64'd0);
  endtask

  // annul_i held with start_i in IDLE must keep the divider idle
  task automatic idle_annul();
    @(negedge clk);
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    check("idle_annul_blocks", 64'(dbg_state), 64'd0);
  endtask

  // Abort a division with reset 15 cycles in, then restart right after release
  task automatic mid_reset();
    int acc;
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5000;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    acc = edge_cnt + 1;
    while (edge_cnt < acc + 15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("reset_async_state", 64'(dbg_state), 64'd0);
    check("reset_async_ready", 64'(bus.ready_o), 64'd0);
    check("reset_async_result", bus.result_o, 64'h0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    // do_div raises start before the first edge after release
    do_div(1'b0, 32'd5000, 32'd7);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    int          wait_n;

    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7);
    @(negedge clk);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b0, 32'hFFFF_FFF9, 32'd2);
    do_div(1'b0, 32'h1234_5678, 32'h0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h1);
    do_div(1'b0, 32'd3, 32'd10);

    // Flush cases: during ON, in DIVZERO, in END, and in IDLE
    do_annul(1'b0, 32'd1000, 32'd3, 10);
    do_div(1'b0, 32'd1000, 32'd3);
    do_annul(1'b0, 32'd1000, 32'h0, 1);
    do_annul(1'b1, 32'hFFFF_FF00, 32'd9, 33);
    idle_annul();

    mid_reset();

    // Random traffic, mixing back-to-back and gapped requests
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h1;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      do_div(s, a, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
